// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

    localparam int IdleLevel = 1;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: free-running modulo-ClksPerBit counter with a synchronous clear.
// tick_o marks the last clk_i cycle of each bit period.
module baud_tick_gen #(
    parameter int unsigned ClksPerBit = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clear_i || (cnt_q == CntMax)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == CntMax);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a first-word-fall-through FIFO one word at a time and sends each word
// as an 8N1-style UART frame (start, LSB-first data, StopBits stop bits).
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned WordLength = 8,
    parameter int unsigned ClksPerBit = 16,
    parameter int unsigned StopBits   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fifo_empty_i,
    input  logic [WordLength-1:0] fifo_data_i,
    output logic                  fifo_rd_o,
    output logic                  tx_o,
    output logic                  busy_o
);

    localparam int unsigned BitCntW = $clog2(WordLength) + 1;
    localparam logic [BitCntW-1:0] LastData = BitCntW'(WordLength - 1);
    localparam logic [BitCntW-1:0] LastStop = BitCntW'(StopBits - 1);

    tx_state_e state_q, state_d;

    logic [WordLength-1:0] shift_q, shift_d;
    logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
    logic                  fifo_rd_q, fifo_rd_d;
    logic                  busy_q, busy_d;
    logic                  tick;
    logic                  pop;

    // The pop strobe is registered one cycle ahead; the IDLE cycle it is high in
    // is the cycle the word is consumed and the frame is launched.
    assign pop = (state_q == IDLE) && fifo_rd_q;

    baud_tick_gen #(
        .ClksPerBit(ClksPerBit)
    ) u_baud_tick_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear_i(pop),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d   = START;
                    shift_d   = fifo_data_i;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LastData) begin
                        state_d   = STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitCntW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt_q == LastStop) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitCntW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so each flop lines up with its state.
    always_comb begin
        fifo_rd_d = (state_d == IDLE) && !fifo_empty_i;
        busy_d    = (state_d != IDLE) || fifo_rd_d;
        case (state_d)
            IDLE:    tx_d = 1'(IdleLevel);
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'(IdleLevel);
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'(IdleLevel);
            fifo_rd_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            fifo_rd_q <= fifo_rd_d;
            busy_q    <= busy_d;
        end
    end

    assign tx_o      = tx_q;
    assign fifo_rd_o = fifo_rd_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: lane 0 uses one stop bit, lane 1 uses two. Each lane has a
// queue-based FIFO and a frame-level reference model checked every cycle.
module tb_fifo_uart_tx;

    localparam int Cpb = 16;

    logic       clk;
    logic       rst;
    logic       fifo_empty [2];
    logic [7:0] fifo_data  [2];
    logic       fifo_rd    [2];
    logic       tx         [2];
    logic       busy       [2];

    logic [7:0] fq   [2][$];
    logic [7:0] junk [2];
    int         pop_cnt [2];

    int tests;
    int fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void refresh(input int i);
        fifo_empty[i] = (fq[i].size() == 0);
        fifo_data[i]  = (fq[i].size() == 0) ? junk[i] : fq[i][0];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_lane
        bit exp_tx[$];

        fifo_uart_tx #(
            .WordLength(8),
            .ClksPerBit(Cpb),
            .StopBits  (g + 1)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .fifo_empty_i(fifo_empty[g]),
            .fifo_data_i (fifo_data[g]),
            .fifo_rd_o   (fifo_rd[g]),
            .tx_o        (tx[g]),
            .busy_o      (busy[g])
        );

        // Model: a pop launches a frame one cycle later; between frames the line idles
        // high, and a waiting word must be popped right after the previous frame ends.
        initial begin
            logic       rd_s;
            logic [7:0] w;
            int         streak;
            bit         just_ended;
            bit         frame_on;
            rd_s       = 1'b0;
            streak     = 0;
            just_ended = 1'b0;
            forever begin
                @(negedge clk);
                rd_s = fifo_rd[g];
                if (rst) begin
                    chk($sformatf("lane%0d_rst_tx", g), int'(tx[g]), 1);
                    chk($sformatf("lane%0d_rst_busy", g), int'(busy[g]), 0);
                    chk($sformatf("lane%0d_rst_rd", g), int'(fifo_rd[g]), 0);
                    exp_tx.delete();
                    streak     = 0;
                    just_ended = 1'b0;
                    rd_s       = 1'b0;
                end else begin
                    frame_on = (exp_tx.size() > 0);
                    if (rd_s) begin
                        pop_cnt[g]++;
                        chk($sformatf("lane%0d_pop_legal", g),
                            int'(frame_on || fifo_empty[g]), 0);
                    end
                    chk($sformatf("lane%0d_tx", g), int'(tx[g]),
                        frame_on ? int'(exp_tx.pop_front()) : 1);
                    chk($sformatf("lane%0d_busy", g), int'(busy[g]), int'(frame_on || rd_s));
                    if (!frame_on && !rd_s && !fifo_empty[g]) begin
                        chk($sformatf("lane%0d_pop_latency", g),
                            int'(just_ended || (streak > 0)), 0);
                        streak++;
                    end else begin
                        streak = 0;
                    end
                    just_ended = frame_on && (exp_tx.size() == 0);
                    if (rd_s && (fq[g].size() > 0)) begin
                        w = fq[g][0];
                        for (int k = 0; k < Cpb; k++) exp_tx.push_back(1'b0);
                        for (int b = 0; b < 8; b++)
                            for (int k = 0; k < Cpb; k++) exp_tx.push_back(w[b]);
                        for (int k = 0; k < (g + 1) * Cpb; k++) exp_tx.push_back(1'b1);
                    end
                end
                @(posedge clk);
                #1;
                if (rd_s && (fq[g].size() > 0)) begin
                    w = fq[g].pop_front();
                    refresh(g);
                end
            end
        end
    end

    task automatic wait_pop(input int i, input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 64 && !seen; n++) begin
            @(negedge clk);
            if (fifo_rd[i]) seen = 1'b1;
        end
        chk(name, int'(seen), 1);
    endtask

    // Called at the negedge of the pop cycle; samples mid-bit and counts busy cycles.
    task automatic capture(input int i, output logic [10:0] bits, output int busy_n);
        int f;
        bits   = '1;
        busy_n = busy[i] ? 1 : 0;
        for (int j = 1; j <= 200; j++) begin
            @(negedge clk);
            if (busy[i]) busy_n++;
            f = j - 1;
            if ((f % Cpb == 8) && (f / Cpb < 11)) bits[f / Cpb] = tx[i];
        end
    endtask

    initial begin
        logic [10:0] bits;
        int          busy_n;
        int          bad;
        int          tx_low;
        int          p0;

        tests = 0;
        fails = 0;
        pop_cnt[0] = 0;
        pop_cnt[1] = 0;
        junk[0] = 8'h00;
        junk[1] = 8'h00;
        refresh(0);
        refresh(1);
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("reset_tx_async", int'(tx[0]), 1);
        chk("reset_busy", int'(busy[0]), 0);
        chk("reset_rd", int'(fifo_rd[0]), 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || fifo_rd[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
        end
        chk("reset_idle_window", bad, 0);

        // Single word 0xA5.
        p0 = pop_cnt[0];
        @(posedge clk); #2;
        fq[0].push_back(8'hA5);
        refresh(0);
        wait_pop(0, "a5_pop_seen");
        capture(0, bits, busy_n);
        chk("a5_bits", int'(bits[9:0]), int'(10'b1101001010));
        chk("a5_busy_cycles", busy_n, 161);
        chk("a5_pops", pop_cnt[0] - p0, 1);

        // Back-to-back 0x00, 0xFF, 0x3C.
        p0 = pop_cnt[0];
        @(posedge clk); #2;
        fq[0].push_back(8'h00);
        fq[0].push_back(8'hFF);
        fq[0].push_back(8'h3C);
        refresh(0);
        wait_pop(0, "b2b_pop_seen");
        busy_n = 1;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (!busy[0]) break;
            busy_n++;
        end
        chk("b2b_busy_cycles", busy_n, 483);
        chk("b2b_pops", pop_cnt[0] - p0, 3);
        chk("b2b_fifo_empty", int'(fifo_empty[0]), 1);

        // Two stop bits on lane 1, word 0x81.
        @(posedge clk); #2;
        fq[1].push_back(8'h81);
        refresh(1);
        wait_pop(1, "two_stop_pop_seen");
        capture(1, bits, busy_n);
        chk("two_stop_bits", int'(bits), int'(11'b11100000010));
        chk("two_stop_busy_cycles", busy_n, 177);

        // Reset during data bit 4 of 0x5A, then 0xC3 must go out intact.
        p0 = pop_cnt[0];
        @(posedge clk); #2;
        fq[0].push_back(8'h5A);
        fq[0].push_back(8'hC3);
        refresh(0);
        wait_pop(0, "rst_mid_pop_seen");
        repeat (1 + Cpb + 4 * Cpb + 4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_tx", int'(tx[0]), 1);
        chk("rst_mid_busy", int'(busy[0]), 0);
        chk("rst_mid_rd", int'(fifo_rd[0]), 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        wait_pop(0, "c3_pop_seen");
        capture(0, bits, busy_n);
        chk("c3_bits", int'(bits[9:0]), int'(10'b1110000110));
        chk("rst_mid_pops", pop_cnt[0] - p0, 2);

        // Empty guard with junk on the data bus.
        bad    = 0;
        tx_low = 0;
        for (int n = 0; n < 500; n++) begin
            @(posedge clk); #2;
            junk[0] = 8'($urandom);
            refresh(0);
            @(negedge clk);
            if (fifo_rd[0]) bad++;
            if (!tx[0]) tx_low++;
        end
        chk("guard_no_pop", bad, 0);
        chk("guard_tx_high", tx_low, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream drain stage for the FIFO. It pops one word at a time from the FIFO read side and serializes it as a UART frame on tx_o.
- A frame is 1 start bit, WordLength data bits LSB-first, no parity, and StopBits stop bits.
- It sits between the TX FIFO and the pad. Software/upstream logic fills the FIFO; this block empties it at the line rate.

Parameters:
- WordLength, 8, data bits per frame; must equal the FIFO word width.
- ClksPerBit, 16, clk_i cycles per bit period; must be ≥ 2.
- StopBits, 1, number of stop bits; legal values are 1 or 2.

Ports:
- clk_i  input  1  system clock; all logic on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- fifo_empty_i  input  1  FIFO empty flag (FIFO empty_o).
- fifo_data_i  input  WordLength  FIFO head word (FIFO r_data_o), valid whenever fifo_empty_i=0.
- fifo_rd_o  output  1  pop strobe to FIFO rd_i; exactly one cycle per word consumed.
- tx_o  output  1  serial line; idles high.
- busy_o  output  1  high from the pop cycle through the last stop-bit cycle.

Behaviour:
- FIFO read contract: the FIFO is first-word fall-through.
  - fifo_data_i shows the head word combinationally while fifo_empty_i=0.
  - A 1-cycle fifo_rd_o advances the read pointer at the next edge.
- Reset values (asynchronous): state=IDLE, tx_o=1, fifo_rd_o=0, busy_o=0, bit counter=0, baud counter=0, shift register=0.
- Deasserting reset mid-frame restarts cleanly in IDLE. A word already popped is lost; this is by design.
- States and transitions:
  - IDLE: tx_o=1. If fifo_empty_i=0, assert fifo_rd_o for this cycle (registered so it is glitch-free), capture fifo_data_i into the shift register, go to START.
  - START: tx_o=0 for ClksPerBit cycles, then go to DATA.
  - DATA: tx_o=shift[0] for ClksPerBit cycles per bit; shift right after each bit. After bit WordLength-1, go to STOP.
  - STOP: tx_o=1 for StopBits*ClksPerBit cycles, then go to IDLE.
- fifo_rd_o is asserted only when fifo_empty_i=0, so a pop on an empty FIFO never occurs.
- Latency: the start bit begins on tx_o one cycle after the pop cycle.
- Frame length: (1+WordLength+StopBits)*ClksPerBit cycles.
- Back-to-back operation: on STOP exit, if the FIFO is non-empty, the next pop happens in the single IDLE cycle.
  - Inter-frame gap is therefore exactly 1 clk_i cycle of idle-high beyond the stop bits.
  - busy_o drops for that cycle only if the FIFO is empty; otherwise it stays high.
- Baud counter:
  - Width $clog2(ClksPerBit).
  - Counts 0..ClksPerBit-1 and wraps; the bit boundary is at ClksPerBit-1.
  - Cleared on entry to START.
- Bit counter:
  - Width $clog2(WordLength)+1.
  - Also counts stop bits, with no overflow for WordLength up to 2^AddrBits-independent widths.
- Simultaneous events:
  - fifo_empty_i rising in the same cycle as a pop has no effect on the current frame.
  - Upstream writes during a frame are FIFO-internal.
- tx_o is driven directly from a flop, with no combinational path from inputs.

Decomposition:
- uart_pkg holds:
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e.
  - localparam int IdleLevel = 1.
- One sub-module, baud_tick_gen, parameter ClksPerBit.
  - Inputs: clk_i, rst_i, clear_i.
  - Output: tick_o, a 1-cycle pulse on the last cycle of each bit period.
- Top-level FSM and shifter live in fifo_uart_tx.

Test Plan:
- Reset idle: assert rst_i for 3 cycles with the FIFO empty → tx_o=1, fifo_rd_o=0, busy_o=0 for 100 cycles after release.
- Single word: FIFO holds 8'hA5, ClksPerBit=16, StopBits=1.
  - fifo_rd_o pulses exactly once.
  - tx_o carries 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; 160 cycles total.
  - busy_o then drops.
- Back-to-back: FIFO preloaded with 8'h00, 8'hFF, 8'h3C.
  - Three frames, each gap 1 cycle.
  - Three pops total; busy_o stays high throughout.
  - Final FIFO empty_o=1.
- Two stop bits: StopBits=2, word 8'h81 → stop phase lasts 32 cycles; total frame 176 cycles.
- Reset mid-frame: assert rst_i during DATA bit 4 of 8'h5A.
  - tx_o=1 immediately (asynchronous), state IDLE, no extra pop.
  - The next queued word 8'hC3 transmits correctly after release.
- Empty guard: hold fifo_empty_i=1 with fifo_data_i toggling randomly for 500 cycles → fifo_rd_o never asserted, tx_o constant 1.
